// File: rtl/fp16_sub_scheduler.sv
// fp16_sub_scheduler: arbitrates two requesters onto one shared combinational
// FP16 subtractor and holds each result in a response register for a consumer.
// Latency: response valid SUB_LAT cycles after the acceptance edge; issue interval SUB_LAT+2.
// Backpressure: one operation in flight; both readys low until the response handshakes.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req{0,1}_valid/ready/a/b      requester handshakes and FP16 operands
//   sub_a, sub_b, sub_diff        registered operands out to / difference back from the subtractor
//   rsp_valid/ready/id/data       response handshake, owning requester, captured difference
//   busy                          high whenever the FSM is not IDLE
module fp16_sub_scheduler #(
  parameter int SUB_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] sub_a,
  output logic [15:0] sub_b,
  input  logic [15:0] sub_diff,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        rr;
  logic [2:0]  cnt;
  logic        gnt;
  logic        accept;

  // Grant: a lone valid requester wins; on a tie or when nobody asks the
  // round-robin pointer decides, so ready is always presented to someone in IDLE.
  always_comb begin
    gnt = rr;
    if (req0_valid && !req1_valid) begin
      gnt = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      gnt = 1'b1;
    end
    accept     = (state == IDLE) && (gnt ? req1_valid : req0_valid);
    req0_ready = (state == IDLE) && !gnt;
    req1_ready = (state == IDLE) &&  gnt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands stay registered until the next acceptance so the shared
  // subtractor sees stable inputs for the whole SUB_LAT window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      cnt      <= 3'd0;
      sub_a    <= 16'h0000;
      sub_b    <= 16'h0000;
      rsp_id   <= 1'b0;
      rsp_data <= 16'h0000;
    end else begin
      if (accept) begin
        sub_a  <= gnt ? req1_a : req0_a;
        sub_b  <= gnt ? req1_b : req0_b;
        rsp_id <= gnt;
        rr     <= ~gnt;
        cnt    <= 3'(SUB_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        // cnt == 1 marks the last cycle of the subtractor's settling window.
        if (cnt == 3'd1) begin
          rsp_data <= sub_diff;
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp16_sub_scheduler.sv
module tb_fp16_sub_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with SUB_LAT = 1
  logic        r0v, r0r, r1v, r1r;
  logic [15:0] r0a, r0b, r1a, r1b, sa, sb, sd, rdat;
  logic        rv, rrdy, rid, bsy;

  // Instance with SUB_LAT = 4
  logic        q0v, q0r, q1v, q1r;
  logic [15:0] q0a, q0b, q1a, q1b, qsa, qsb, qsd, qdat;
  logic        qv, qrdy, qid, qbsy;

  logic [15:0] cyc = 16'h0000;
  always @(posedge clk) cyc <= cyc + 16'd1;

  int vectors = 0;
  int miscompares = 0;
  int popped = 0;
  logic [16:0] exp_q[$];

  function automatic logic [15:0] bench_sub(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h4200 && b == 16'h3C00) return 16'h4000;
    return a ^ {b[7:0], b[15:8]};
  endfunction

  assign sd  = bench_sub(sa, sb);
  assign qsd = 16'hA000 + cyc;

  fp16_sub_scheduler #(.SUB_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
    .sub_a(sa), .sub_b(sb), .sub_diff(sd),
    .rsp_valid(rv), .rsp_ready(rrdy), .rsp_id(rid), .rsp_data(rdat), .busy(bsy)
  );

  fp16_sub_scheduler #(.SUB_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q0v), .req0_ready(q0r), .req0_a(q0a), .req0_b(q0b),
    .req1_valid(q1v), .req1_ready(q1r), .req1_a(q1a), .req1_b(q1b),
    .sub_a(qsa), .sub_b(qsb), .sub_diff(qsd),
    .rsp_valid(qv), .rsp_ready(qrdy), .rsp_id(qid), .rsp_data(qdat), .busy(qbsy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected {id, data} pushed by the stimulus, popped on each handshake.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (rv && rrdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("sb_rsp_id", rid, e[16]);
        chk("sb_rsp_data", rdat, e[15:0]);
      end
      popped++;
    end
  end

  initial begin
    int k;
    int n;
    int p0;
    logic [15:0] c0;

    rst_n = 1'b0;
    r0v = 0; r1v = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0; rrdy = 0;
    q0v = 0; q1v = 0; q0a = 0; q0b = 0; q1a = 0; q1b = 0; qrdy = 0;
    #3;
    chk("rst_sub_a", sa, 16'h0000);
    chk("rst_sub_b", sb, 16'h0000);
    chk("rst_rsp_data", rdat, 16'h0000);
    chk("rst_rsp_id", rid, 1'b0);
    chk("rst_rsp_valid", rv, 1'b0);
    chk("rst_busy", bsy, 1'b0);
    chk("rst_req0_ready", r0r, 1'b1);
    chk("rst_req1_ready", r1r, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single operation through requester 0
    r0a = 16'h4200; r0b = 16'h3C00; r0v = 1'b1;
    exp_q.push_back({1'b0, 16'h4000});
    #1;
    chk("single_req0_ready", r0r, 1'b1);
    chk("single_req1_ready", r1r, 1'b0);
    tick();
    r0v = 1'b0;
    #1;
    chk("single_busy_wait", bsy, 1'b1);
    chk("single_sub_a", sa, 16'h4200);
    chk("single_sub_b", sb, 16'h3C00);
    chk("single_ready_wait", {r0r, r1r}, 2'b00);
    k = 0;
    while (!rv && k < 10) begin
      tick();
      k++;
    end
    chk("single_latency", k + 1, 2);
    chk("single_rsp_data", rdat, 16'h4000);
    chk("single_rsp_id", rid, 1'b0);
    chk("single_busy_resp", bsy, 1'b1);
    rrdy = 1'b1;
    tick();
    chk("single_rsp_done", rv, 1'b0);
    chk("single_idle", bsy, 1'b0);
    tick();
    chk("rsp_ready_ignored_idle", bsy, 1'b0);
    chk("single_sb_empty", exp_q.size(), 0);
    rrdy = 1'b0;

    // Reset while WAIT: the op is discarded and rr returns to 0 (it was 1)
    r0a = 16'h1111; r0b = 16'h2222; r0v = 1'b1;
    tick();
    r0v = 1'b0;
    chk("midwait_busy", bsy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_rst_busy", bsy, 1'b0);
    chk("midwait_rst_sub_a", sa, 16'h0000);
    chk("midwait_rst_sub_b", sb, 16'h0000);
    chk("midwait_rst_rsp_data", rdat, 16'h0000);
    chk("midwait_rst_rsp_id", rid, 1'b0);
    chk("midwait_rst_rsp_valid", rv, 1'b0);
    chk("midwait_rst_req0_ready", r0r, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midwait_no_rsp", rv, 1'b0);
    end

    // Contention: both valid continuously, grants alternate starting at 0
    r0a = 16'h3C00; r0b = 16'h3800; r1a = 16'h4400; r1b = 16'h4000;
    exp_q.push_back({1'b0, bench_sub(16'h3C00, 16'h3800)});
    exp_q.push_back({1'b1, bench_sub(16'h4400, 16'h4000)});
    exp_q.push_back({1'b0, bench_sub(16'h3C00, 16'h3800)});
    exp_q.push_back({1'b1, bench_sub(16'h4400, 16'h4000)});
    r0v = 1'b1; r1v = 1'b1; rrdy = 1'b1;
    #1;
    chk("cont_first_grant", {r0r, r1r}, 2'b10);
    p0 = popped;
    n = 0;
    while ((popped - p0) < 4 && n < 40) begin
      tick();
      n++;
    end
    r0v = 1'b0; r1v = 1'b0; rrdy = 1'b0;
    chk("cont_cycles", n, 12);
    chk("cont_sb_empty", exp_q.size(), 0);

    // Backpressure, with a withdrawn req1 pulse while busy
    r0a = 16'h1234; r0b = 16'h0567; r0v = 1'b1;
    exp_q.push_back({1'b0, bench_sub(16'h1234, 16'h0567)});
    tick();
    r0v = 1'b0;
    tick();
    chk("bp_rsp_valid", rv, 1'b1);
    for (int i = 0; i < 5; i++) begin
      r1v = (i == 1 || i == 2);
      r1a = 16'h7777; r1b = 16'h1111;
      #1;
      chk("bp_hold_valid", rv, 1'b1);
      chk("bp_hold_data", rdat, bench_sub(16'h1234, 16'h0567));
      chk("bp_hold_id", rid, 1'b0);
      chk("bp_readys_low", {r0r, r1r}, 2'b00);
      chk("bp_sub_a", sa, 16'h1234);
      chk("bp_sub_b", sb, 16'h0567);
      tick();
    end
    r1v = 1'b0;
    rrdy = 1'b1;
    tick();
    rrdy = 1'b0;
    #1;
    chk("bp_released", bsy, 1'b0);
    chk("withdraw_rr_kept", {r0r, r1r}, 2'b01);
    tick();
    tick();
    chk("withdraw_no_accept", bsy, 1'b0);
    chk("bp_sb_empty", exp_q.size(), 0);

    // SUB_LAT = 4 with a subtractor output that changes every cycle
    q0a = 16'h4500; q0b = 16'h3C00; q0v = 1'b1;
    #1;
    chk("lat4_req0_ready", q0r, 1'b1);
    tick();
    q0v = 1'b0;
    c0 = cyc;
    k = 0;
    while (!qv && k < 20) begin
      tick();
      k++;
    end
    chk("lat4_edges_to_valid", k, 4);
    chk("lat4_rsp_data", qdat, 16'hA000 + c0 + 16'd3);
    chk("lat4_rsp_id", qid, 1'b0);
    chk("lat4_sub_a", qsa, 16'h4500);
    qrdy = 1'b1;
    tick();
    qrdy = 1'b0;
    chk("lat4_idle", qbsy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
